// File: rtl/lcd_spi_tx.sv
// FIFO-buffered SPI transmit master for ST7789-class display panels.
// Frames of {dc, data} are queued and shifted out MSB-first with a programmable SCL rate.

module lcd_spi_tx #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 4,
    parameter int HALF_DIV = 2,
    parameter int CPOL     = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic                   in_dc_i,
    input  logic [DATA_W-1:0]      in_data_i,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   busy_o,
    output logic                   frame_done_o,
    output logic                   spi_sda_o,
    output logic                   spi_scl_o,
    output logic                   spi_dc_o,
    output logic                   spi_cs_n_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(HALF_DIV) + 1;
    localparam int BW = $clog2(DATA_W) + 1;
    localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] DIV_LAST = CW'(HALF_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
    localparam logic          IDLE_SCL = 1'(CPOL);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SETUP,
        S_ACTIVE
    } state_t;

    logic [DATA_W:0]   mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic [AW:0]       count_n;
    logic              full;
    logic              push;
    logic              load;

    state_t            state, state_n;
    logic [CW-1:0]     div_cnt, div_n;
    logic [BW-1:0]     bit_cnt, bit_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic              sda, sda_n;
    logic              scl, scl_n;
    logic              dc, dc_n;
    logic              cs_n, cs_n_n;
    logic              done, done_n;
    logic              busy, busy_n;

    assign full = (count == FULL_LVL);
    assign push = in_valid_i && !full;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= {in_dc_i, in_data_i};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (load) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_n;
        end
    end

    always_comb begin
        count_n = count;
        if (push && !load) begin
            count_n = count + 1'b1;
        end else if (load && !push) begin
            count_n = count - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= S_IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            sda     <= 1'b0;
            scl     <= IDLE_SCL;
            dc      <= 1'b0;
            cs_n    <= 1'b1;
            done    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            div_cnt <= div_n;
            bit_cnt <= bit_n;
            shreg   <= shreg_n;
            sda     <= sda_n;
            scl     <= scl_n;
            dc      <= dc_n;
            cs_n    <= cs_n_n;
            done    <= done_n;
            busy    <= busy_n;
        end
    end

    // Every pin is registered; a load is taken on the edge entering LOAD so the
    // head frame's MSB and DC are already on the pins during the LOAD cycle.
    always_comb begin
        state_n = state;
        div_n   = div_cnt;
        bit_n   = bit_cnt;
        shreg_n = shreg;
        sda_n   = sda;
        scl_n   = scl;
        dc_n    = dc;
        cs_n_n  = cs_n;
        done_n  = 1'b0;
        load    = 1'b0;

        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    state_n = S_LOAD;
                    load    = 1'b1;
                end
            end
            S_LOAD: begin
                state_n = S_SETUP;
                div_n   = DIV_LAST;
            end
            S_SETUP: begin
                if (div_cnt == '0) begin
                    state_n = S_ACTIVE;
                    scl_n   = !IDLE_SCL;
                    div_n   = DIV_LAST;
                end else begin
                    div_n = div_cnt - 1'b1;
                end
            end
            S_ACTIVE: begin
                if (div_cnt == '0) begin
                    scl_n = IDLE_SCL;
                    if (bit_cnt != '0) begin
                        shreg_n = shreg << 1;
                        sda_n   = shreg_n[DATA_W-1];
                        bit_n   = bit_cnt - 1'b1;
                        state_n = S_SETUP;
                        div_n   = DIV_LAST;
                    end else begin
                        done_n = 1'b1;
                        if (count != '0) begin
                            state_n = S_LOAD;
                            load    = 1'b1;
                        end else begin
                            state_n = S_IDLE;
                            cs_n_n  = 1'b1;
                        end
                    end
                end else begin
                    div_n = div_cnt - 1'b1;
                end
            end
            default: begin
                state_n = S_IDLE;
                cs_n_n  = 1'b1;
                scl_n   = IDLE_SCL;
            end
        endcase

        if (load) begin
            shreg_n = mem[rd_ptr][DATA_W-1:0];
            dc_n    = mem[rd_ptr][DATA_W];
            sda_n   = mem[rd_ptr][DATA_W-1];
            cs_n_n  = 1'b0;
            bit_n   = BIT_LAST;
            div_n   = DIV_LAST;
        end

        busy_n = (state_n != S_IDLE) || (count_n != '0);
    end

    assign in_ready_o   = !full;
    assign level_o      = count;
    assign busy_o       = busy;
    assign frame_done_o = done;
    assign spi_sda_o    = sda;
    assign spi_scl_o    = scl;
    assign spi_dc_o     = dc;
    assign spi_cs_n_o   = cs_n;

endmodule

// File: tb/tb_lcd_spi_tx.sv
// Self-checking bench for lcd_spi_tx: a frame-schedule model checks the default
// instance every cycle; a second instance covers CPOL=0, HALF_DIV=1, DATA_W=16.

module tb_lcd_spi_tx;

    localparam int   DW0    = 8;
    localparam int   DEPTH0 = 4;
    localparam int   HD0    = 2;
    localparam logic CPOL0  = 1'b1;
    localparam int   FLEN0  = 1 + 2 * HD0 * DW0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       in_valid = 1'b0, in_dc = 1'b0, in_ready;
    logic [7:0] in_data = '0;
    logic [2:0] level;
    logic       busy, done, sda, scl, dc, cs_n;

    logic        in_valid1 = 1'b0, in_dc1 = 1'b0, in_ready1;
    logic [15:0] in_data1 = '0;
    logic [2:0]  level1;
    logic        busy1, done1, sda1, scl1, dc1, cs_n1;

    lcd_spi_tx #(.DATA_W(DW0), .DEPTH(DEPTH0), .HALF_DIV(HD0), .CPOL(1)) dut0 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_dc_i(in_dc), .in_data_i(in_data), .level_o(level), .busy_o(busy),
        .frame_done_o(done), .spi_sda_o(sda), .spi_scl_o(scl), .spi_dc_o(dc),
        .spi_cs_n_o(cs_n)
    );

    lcd_spi_tx #(.DATA_W(16), .DEPTH(4), .HALF_DIV(1), .CPOL(0)) dut1 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid1), .in_ready_o(in_ready1),
        .in_dc_i(in_dc1), .in_data_i(in_data1), .level_o(level1), .busy_o(busy1),
        .frame_done_o(done1), .spi_sda_o(sda1), .spi_scl_o(scl1), .spi_dc_o(dc1),
        .spi_cs_n_o(cs_n1)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic check_en = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Frame-schedule model: a queue of waiting frames plus the cycle offset
    // inside the frame currently on the wire (-1 when nothing is on the wire).
    logic [8:0] m_q[$];
    logic [8:0] m_cur = '0;
    int         m_pos = -1;
    logic       m_done = 1'b0;
    logic       m_dc = 1'b0;
    logic       m_acc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_pos  = -1;
            m_done = 1'b0;
            m_dc   = 1'b0;
        end else begin
            m_acc  = in_valid && (m_q.size() < DEPTH0);
            m_done = 1'b0;
            if (m_pos >= 0) begin
                m_pos++;
                if (m_pos == FLEN0) begin
                    m_done = 1'b1;
                    m_pos  = -1;
                end
            end
            if (m_pos < 0 && m_q.size() != 0) begin
                m_cur = m_q.pop_front();
                m_pos = 0;
                m_dc  = m_cur[8];
            end
            if (m_acc) m_q.push_back({in_dc, in_data});
        end
    end

    always @(negedge clk) begin : compare
        int   ph, b;
        logic e_scl;
        if (!rst && check_en) begin
            e_scl = CPOL0;
            b     = 0;
            if (m_pos > 0) begin
                ph    = (m_pos - 1) % (2 * HD0);
                b     = (m_pos - 1) / (2 * HD0);
                e_scl = (ph < HD0) ? CPOL0 : !CPOL0;
            end
            checkOutput("ready", in_ready, m_q.size() < DEPTH0);
            checkOutput("level", level, m_q.size());
            checkOutput("busy", busy, (m_pos >= 0) || (m_q.size() != 0));
            checkOutput("done", done, m_done);
            checkOutput("scl", scl, e_scl);
            checkOutput("cs_n", cs_n, m_pos < 0);
            checkOutput("dc", dc, m_dc);
            if (m_pos >= 0) checkOutput("sda", sda, m_cur[7-b]);
        end
    end

    // Slave-side observers: record the {dc, sda} seen just before each trailing edge.
    logic [1:0] cap0[$];
    logic [1:0] cap1[$];
    logic prev_scl0 = 1'b1, prev_sda0 = 1'b0, prev_dc0 = 1'b0, prev_cs0 = 1'b1, prev_busy0 = 1'b0;
    logic prev_scl1 = 1'b0, prev_sda1 = 1'b0, prev_dc1 = 1'b0;
    int   scl_edges0 = 0, cs_changes0 = 0, busy_changes0 = 0, done_cnt0 = 0, max_level0 = 0;
    int   run0 = 0, last_run0 = 0, run1 = 0, last_run1 = 0, done_cnt1 = 0;
    logic full_seen = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prev_scl0 = CPOL0; prev_sda0 = 1'b0; prev_dc0 = 1'b0; prev_cs0 = 1'b1; prev_busy0 = 1'b0;
            prev_scl1 = 1'b0;  prev_sda1 = 1'b0; prev_dc1 = 1'b0;
            run0 = 0; run1 = 0;
        end else begin
            if (prev_scl0 != CPOL0 && scl == CPOL0) cap0.push_back({prev_dc0, prev_sda0});
            if (scl != prev_scl0) scl_edges0++;
            if (cs_n != prev_cs0) cs_changes0++;
            if (busy != prev_busy0) busy_changes0++;
            if (done) done_cnt0++;
            if (int'(level) > max_level0) max_level0 = int'(level);
            if (level == 3'd4 && !in_ready) full_seen = 1'b1;
            if (!cs_n) run0++;
            else if (run0 > 0) begin last_run0 = run0; run0 = 0; end
            prev_scl0 = scl; prev_sda0 = sda; prev_dc0 = dc; prev_cs0 = cs_n; prev_busy0 = busy;

            if (prev_scl1 == 1'b1 && scl1 == 1'b0) cap1.push_back({prev_dc1, prev_sda1});
            if (done1) done_cnt1++;
            if (!cs_n1) run1++;
            else if (run1 > 0) begin last_run1 = run1; run1 = 0; end
            prev_scl1 = scl1; prev_sda1 = sda1; prev_dc1 = dc1;
        end
    end

    // Push one frame into the chosen instance, holding valid until it is accepted.
    task automatic applyStimulus(input int port, input logic fdc, input logic [15:0] data);
        int   budget = 200;
        logic acc = 1'b0;
        if (port == 0) begin in_valid = 1'b1; in_dc = fdc; in_data = data[7:0]; end
        else begin in_valid1 = 1'b1; in_dc1 = fdc; in_data1 = data; end
        while (!acc && budget > 0) begin
            @(negedge clk);
            acc = (port == 0) ? in_ready : in_ready1;
            @(posedge clk);
            #1;
            budget--;
        end
        checkOutput("push_accepted", acc, 1);
        in_valid  = 1'b0;
        in_valid1 = 1'b0;
    endtask

    task automatic waitIdle(input int port);
        int budget = 1000;
        do begin
            @(negedge clk);
            budget--;
        end while (((port == 0) ? busy : busy1) && budget > 0);
        checkOutput("idle_reached", (port == 0) ? busy : busy1, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic clearObs();
        cap0.delete(); cap1.delete();
        done_cnt0 = 0; done_cnt1 = 0; last_run0 = 0; last_run1 = 0;
        scl_edges0 = 0; cs_changes0 = 0; busy_changes0 = 0; max_level0 = 0; full_seen = 1'b0;
    endtask

    function automatic logic [15:0] capWord0(input int first);
        logic [15:0] w = '0;
        for (int i = 0; i < 8; i++) w = {w[14:0], cap0[first+i][0]};
        return w;
    endfunction

    logic [8:0] full_vals[6];
    logic [15:0] w1;

    initial begin
        full_vals[0] = 9'h011; full_vals[1] = 9'h122; full_vals[2] = 9'h033;
        full_vals[3] = 9'h144; full_vals[4] = 9'h055; full_vals[5] = 9'h166;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_level", level, 0);
        checkOutput("rst_ready", in_ready, 1);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_scl", scl, 1);
        checkOutput("rst_sda", sda, 0);
        checkOutput("rst_dc", dc, 0);
        checkOutput("rst_cs_n", cs_n, 1);
        checkOutput("rst_scl1", scl1, 0);
        rst = 1'b0;
        check_en = 1'b1;

        // Single frame 0x2A as a command.
        clearObs();
        applyStimulus(0, 1'b0, 16'h002A);
        @(negedge clk);
        checkOutput("single_level_first", level, 1);
        checkOutput("single_cs_before_load", cs_n, 1);
        @(negedge clk);
        checkOutput("single_cs_at_load", cs_n, 0);
        @(posedge clk); #1;
        waitIdle(0);
        checkOutput("single_bits", cap0.size(), 8);
        if (cap0.size() == 8) begin
            checkOutput("single_byte", capWord0(0), 16'h002A);
            checkOutput("single_dc", cap0[0][1], 0);
        end
        checkOutput("single_done_pulses", done_cnt0, 1);
        checkOutput("single_cs_low_cycles", last_run0, 33);

        // Three frames pushed on consecutive cycles.
        clearObs();
        applyStimulus(0, 1'b0, 16'h002A);
        applyStimulus(0, 1'b1, 16'h0000);
        applyStimulus(0, 1'b1, 16'h00EF);
        waitIdle(0);
        checkOutput("b2b_bits", cap0.size(), 24);
        if (cap0.size() == 24) begin
            checkOutput("b2b_byte0", capWord0(0), 16'h002A);
            checkOutput("b2b_byte1", capWord0(8), 16'h0000);
            checkOutput("b2b_byte2", capWord0(16), 16'h00EF);
            checkOutput("b2b_dc0", cap0[7][1], 0);
            checkOutput("b2b_dc1", cap0[8][1], 1);
            checkOutput("b2b_dc2", cap0[16][1], 1);
        end
        checkOutput("b2b_done_pulses", done_cnt0, 3);
        checkOutput("b2b_cs_low_cycles", last_run0, 99);

        // Six frames with valid held high: fills the FIFO and wraps the pointers.
        clearObs();
        for (int i = 0; i < 6; i++) applyStimulus(0, full_vals[i][8], {8'h00, full_vals[i][7:0]});
        waitIdle(0);
        checkOutput("full_max_level", max_level0, 4);
        checkOutput("full_ready_dropped", full_seen, 1);
        checkOutput("full_done_pulses", done_cnt0, 6);
        checkOutput("full_bits", cap0.size(), 48);
        if (cap0.size() == 48) begin
            for (int i = 0; i < 6; i++) begin
                checkOutput($sformatf("full_byte%0d", i), capWord0(8*i), {8'h00, full_vals[i][7:0]});
                checkOutput($sformatf("full_dc%0d", i), cap0[8*i][1], full_vals[i][8]);
            end
        end

        // CPOL=0, HALF_DIV=1, 16-bit instance.
        clearObs();
        applyStimulus(1, 1'b1, 16'hF800);
        waitIdle(1);
        checkOutput("c0_bits", cap1.size(), 16);
        if (cap1.size() == 16) begin
            w1 = '0;
            for (int i = 0; i < 16; i++) w1 = {w1[14:0], cap1[i][0]};
            checkOutput("c0_word", w1, 16'hF800);
            checkOutput("c0_dc", cap1[15][1], 1);
        end
        checkOutput("c0_cs_low_cycles", last_run1, 33);
        checkOutput("c0_done_pulses", done_cnt1, 1);
        checkOutput("c0_scl_idle", scl1, 0);
        checkOutput("c0_level", level1, 0);

        // Asynchronous reset part-way through bit 4 with two frames queued.
        clearObs();
        applyStimulus(0, 1'b0, 16'h00A5);
        applyStimulus(0, 1'b1, 16'h003C);
        applyStimulus(0, 1'b0, 16'h0081);
        repeat (16) @(posedge clk);
        #3;
        checkOutput("mid_cs_n", cs_n, 0);
        checkOutput("mid_level", level, 2);
        rst = 1'b1;
        #1;
        checkOutput("arst_level", level, 0);
        checkOutput("arst_ready", in_ready, 1);
        checkOutput("arst_busy", busy, 0);
        checkOutput("arst_done", done, 0);
        checkOutput("arst_scl", scl, 1);
        checkOutput("arst_sda", sda, 0);
        checkOutput("arst_dc", dc, 0);
        checkOutput("arst_cs_n", cs_n, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        scl_edges0 = 0;
        repeat (20) @(posedge clk);
        #1;
        checkOutput("post_rst_scl_edges", scl_edges0, 0);
        checkOutput("post_rst_cs_n", cs_n, 1);
        checkOutput("post_rst_busy", busy, 0);

        // Long idle stretch: nothing on the pins may move.
        clearObs();
        repeat (1000) @(posedge clk);
        #1;
        checkOutput("idle_scl_edges", scl_edges0, 0);
        checkOutput("idle_cs_changes", cs_changes0, 0);
        checkOutput("idle_busy_changes", busy_changes0, 0);
        checkOutput("idle_scl", scl, 1);
        checkOutput("idle_cs_n", cs_n, 1);
        checkOutput("idle_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit (compared %0d, mismatched %0d)", n_cmp, n_bad);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
